// File: rtl/xor_stream_sequencer.sv
// Purpose: owns the XOR cipher key and phases; loads key segments, then XORs data with the rotating key segment.
// Latency: 1 cycle from data handshake to registered oData/oData_valid; key writes land 1 cycle after handshake.
// Backpressure: oData_ready = !oData_valid | iOut_ready while running; key input is ready only while loading.
module xor_stream_sequencer #(
  parameter int WORD_W    = 32,
  parameter int KEY_WORDS = 16
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic [WORD_W-1:0]             iKey_word,
  input  logic                          iKey_valid,
  output logic                          oKey_ready,
  input  logic [WORD_W-1:0]             iData,
  input  logic                          iData_valid,
  output logic                          oData_ready,
  output logic [WORD_W-1:0]             oData,
  output logic                          oData_valid,
  input  logic                          iOut_ready,
  input  logic                          iRekey,
  output logic                          oCan_encrypt,
  output logic [$clog2(KEY_WORDS):0]    oKey_count,
  output logic [$clog2(KEY_WORDS)-1:0]  oSeg_index
);

  localparam int SEG_W = $clog2(KEY_WORDS);
  localparam int CNT_W = SEG_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_WORDS - 1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(KEY_WORDS - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [WORD_W-1:0]   r_key [KEY_WORDS];
  logic [CNT_W-1:0]    r_key_count;
  logic [SEG_W-1:0]    r_seg_index;
  logic [WORD_W-1:0]   r_data;
  logic                r_data_valid;
  logic                r_can_encrypt;

  logic                w_key_ready;
  logic                w_data_ready;
  logic                w_key_hs;
  logic                w_data_hs;
  logic                w_out_hs;
  logic                w_key_last;
  logic                w_seg_last;
  logic                w_load_done;
  logic                w_drain_done;
  logic [WORD_W-1:0]   w_key_seg;

  // Handshake qualifiers. The count guard keeps a full key from ever taking an extra word.
  assign w_key_ready  = (r_state == S_LOAD) && (r_key_count != CNT_FULL);
  assign w_data_ready = (r_state == S_RUN) && (!r_data_valid || iOut_ready);
  assign w_key_hs     = iKey_valid && w_key_ready;
  assign w_data_hs    = iData_valid && w_data_ready;
  assign w_out_hs     = r_data_valid && iOut_ready;
  assign w_key_last   = (r_key_count == CNT_LAST);
  assign w_seg_last   = (r_seg_index == SEG_LAST);
  assign w_load_done  = w_key_hs && w_key_last;
  assign w_key_seg    = r_key[r_seg_index];

  // Next-state logic: load until the key is full, run until a rekey, drain the output register.
  always_comb begin
    w_state_nxt  = r_state;
    w_drain_done = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_load_done) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (iRekey) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_data_valid) begin
          w_state_nxt  = S_LOAD;
          w_drain_done = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

  // State register; oCan_encrypt is registered so it tracks S_RUN exactly one cycle behind decisions.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state       <= S_LOAD;
      r_can_encrypt <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_can_encrypt <= (w_state_nxt == S_RUN);
    end
  end

  // Key storage: each accepted key word lands in the slot named by the current fill count.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < KEY_WORDS; i++) begin
        r_key[i] <= '0;
      end
    end else if (w_key_hs) begin
      r_key[r_key_count[SEG_W-1:0]] <= iKey_word;
    end
  end

  // Fill counter: only cleared on reset or when a drain completes; stale key bits are simply overwritten.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_key_count <= '0;
    end else if (w_drain_done) begin
      r_key_count <= '0;
    end else if (w_key_hs && (r_key_count != CNT_FULL)) begin
      r_key_count <= r_key_count + 1'b1;
    end
  end

  // Segment pointer: restarts at 0 for every new key and wraps around the key while running.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_seg_index <= '0;
    end else if (w_drain_done || w_load_done) begin
      r_seg_index <= '0;
    end else if (w_data_hs) begin
      r_seg_index <= w_seg_last ? '0 : r_seg_index + 1'b1;
    end
  end

  // Output register: load on input handshake (covers simultaneous drain), else clear valid once taken.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else if (w_data_hs) begin
      r_data       <= iData ^ w_key_seg;
      r_data_valid <= 1'b1;
    end else if (w_out_hs) begin
      r_data_valid <= 1'b0;
    end
  end

  assign oKey_ready   = w_key_ready;
  assign oData_ready  = w_data_ready;
  assign oData        = r_data;
  assign oData_valid  = r_data_valid;
  assign oCan_encrypt = r_can_encrypt;
  assign oKey_count   = r_key_count;
  assign oSeg_index   = r_seg_index;

endmodule

// File: tb/tb_xor_stream_sequencer.sv
// Purpose: directed stimulus with a queue scoreboard for xor_stream_sequencer.
// Latency: expects output one cycle after each accepted data word.
// Backpressure: drives iOut_ready low in windows and checks hold/no-loss behaviour.
module tb_xor_stream_sequencer;

  localparam int WORD_W    = 32;
  localparam int KEY_WORDS = 16;

  logic              iClk        = 1'b0;
  logic              iRst        = 1'b1;
  logic [WORD_W-1:0] iKey_word   = '0;
  logic              iKey_valid  = 1'b0;
  logic [WORD_W-1:0] iData       = '0;
  logic              iData_valid = 1'b0;
  logic              iOut_ready  = 1'b0;
  logic              iRekey      = 1'b0;
  logic              oKey_ready;
  logic              oData_ready;
  logic [WORD_W-1:0] oData;
  logic              oData_valid;
  logic              oCan_encrypt;
  logic [4:0]        oKey_count;
  logic [3:0]        oSeg_index;

  int                checks   = 0;
  int                failures = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] m_key [KEY_WORDS];
  int                m_seg    = 0;
  int                out_cnt  = 0;
  logic              hold_vld = 1'b0;
  logic [WORD_W-1:0] hold_dat = '0;

  always #5 iClk = ~iClk;

  xor_stream_sequencer #(.WORD_W(WORD_W), .KEY_WORDS(KEY_WORDS)) dut (
    .iClk         (iClk),
    .iRst         (iRst),
    .iKey_word    (iKey_word),
    .iKey_valid   (iKey_valid),
    .oKey_ready   (oKey_ready),
    .iData        (iData),
    .iData_valid  (iData_valid),
    .oData_ready  (oData_ready),
    .oData        (oData),
    .oData_valid  (oData_valid),
    .iOut_ready   (iOut_ready),
    .iRekey       (iRekey),
    .oCan_encrypt (oCan_encrypt),
    .oKey_count   (oKey_count),
    .oSeg_index   (oSeg_index)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: on the falling edge, inputs are stable for the coming rising edge.
  always @(negedge iClk) begin
    if (iRst) begin
      exp_q.delete();
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("hold_vld", 32'(oData_valid), 32'd1);
        chk("hold_dat", oData, hold_dat);
      end
      if (oData_valid && iOut_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual=%h expected=none", oData);
        end else begin
          chk("out_dat", oData, exp_q.pop_front());
          out_cnt++;
        end
      end
      hold_vld = oData_valid && !iOut_ready;
      hold_dat = oData;
      if (iData_valid && oData_ready) begin
        chk("seg_idx", 32'(oSeg_index), 32'(m_seg));
        exp_q.push_back(iData ^ m_key[m_seg]);
        m_seg = (m_seg + 1) % KEY_WORDS;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle_inputs();
    iKey_valid  = 1'b0;
    iData_valid = 1'b0;
    iRekey      = 1'b0;
    iKey_word   = '0;
    iData       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    #1;
  endtask

  task automatic load_key(input logic [31:0] base, input logic [31:0] mult);
    for (int i = 0; i < KEY_WORDS; i++) begin
      iKey_valid = 1'b1;
      iKey_word  = base + mult * i;
      m_key[i]   = iKey_word;
      #1;
      chk("key_rdy", 32'(oKey_ready), 32'd1);
      chk("key_cnt", 32'(oKey_count), i);
      chk("can_enc_pre", 32'(oCan_encrypt), 32'd0);
      step();
    end
    iKey_valid = 1'b0;
    m_seg      = 0;
    #1;
    chk("can_enc", 32'(oCan_encrypt), 32'd1);
    chk("key_cnt_full", 32'(oKey_count), 32'd16);
    chk("seg_start", 32'(oSeg_index), 32'd0);
    chk("key_rdy_run", 32'(oKey_ready), 32'd0);
  endtask

  initial begin
    int   sent;
    logic acc;
    logic got;
    logic [31:0] kv;

    idle_inputs();
    iRst = 1'b1;
    step();
    step();
    iRst = 1'b0;
    #1;
    // Reset state
    chk("rst_cnt", 32'(oKey_count), 32'd0);
    chk("rst_seg", 32'(oSeg_index), 32'd0);
    chk("rst_dat", oData, 32'd0);
    chk("rst_vld", 32'(oData_valid), 32'd0);
    chk("rst_can", 32'(oCan_encrypt), 32'd0);
    chk("rst_krdy", 32'(oKey_ready), 32'd1);
    chk("rst_drdy", 32'(oData_ready), 32'd0);

    // 1: key words 0x0..0xF
    load_key(32'h0, 32'h1);

    // 2: key k[i]=0x11111111*i, 20 words of 0xA5A5A5A5
    do_reset();
    load_key(32'h0, 32'h1111_1111);
    iOut_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      iData_valid = 1'b1;
      iData       = 32'hA5A5_A5A5;
      #1;
      chk("run_rdy", 32'(oData_ready), 32'd1);
      step();
      kv = 32'h1111_1111 * 32'(n % 16);
      chk("lat_dat", oData, 32'hA5A5_A5A5 ^ kv);
      chk("lat_vld", 32'(oData_valid), 32'd1);
      if (n == 15) chk("seg_wrap", 32'(oSeg_index), 32'd0);
    end
    iData_valid = 1'b0;
    step();
    step();
    chk("q_empty2", exp_q.size(), 0);
    chk("out_cnt2", out_cnt, 20);

    // 3: iOut_ready low for 5 cycles mid-stream
    sent    = 0;
    out_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      iOut_ready  = !(c >= 4 && c < 9);
      iData_valid = 1'b1;
      iData       = 32'hC000_0000 + sent;
      #1;
      if (c >= 4 && c < 9) begin
        chk("stall_rdy", 32'(oData_ready), 32'd0);
        chk("stall_vld", 32'(oData_valid), 32'd1);
      end
      acc = oData_ready;
      step();
      if (acc) sent++;
    end
    iData_valid = 1'b0;
    iOut_ready  = 1'b1;
    step();
    step();
    chk("sent3", sent, 11);
    chk("out_cnt3", out_cnt, 11);
    chk("q_empty3", exp_q.size(), 0);

    // 4: rekey together with a data handshake while output is blocked
    iOut_ready  = 1'b0;
    iData_valid = 1'b1;
    iData       = 32'h1234_5678;
    iRekey      = 1'b1;
    #1;
    chk("rekey_rdy", 32'(oData_ready), 32'd1);
    step();
    idle_inputs();
    #1;
    chk("rekey_can", 32'(oCan_encrypt), 32'd0);
    chk("rekey_vld", 32'(oData_valid), 32'd1);
    chk("rekey_dat", oData, 32'hEDCB_A987);
    chk("rekey_drdy", 32'(oData_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("drain_krdy", 32'(oKey_ready), 32'd0);
      chk("drain_vld", 32'(oData_valid), 32'd1);
      chk("drain_cnt", 32'(oKey_count), 32'd16);
    end
    iOut_ready = 1'b1;
    step();
    iOut_ready = 1'b0;
    #1;
    chk("drain_taken", 32'(oData_valid), 32'd0);
    chk("drain_still", 32'(oKey_ready), 32'd0);
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      step();
      got = oKey_ready;
    end
    chk("drain_exit", 32'(got), 32'd1);
    chk("reload_cnt", 32'(oKey_count), 32'd0);
    chk("reload_can", 32'(oCan_encrypt), 32'd0);
    chk("reload_seg", 32'(oSeg_index), 32'd0);
    load_key(32'hF0F0_0000, 32'h1);
    iOut_ready  = 1'b1;
    iData_valid = 1'b1;
    iData       = 32'h0F0F_0000;
    step();
    iData_valid = 1'b0;
    #1;
    chk("newkey_dat", oData, 32'hFFFF_0000);
    step();
    chk("q_empty4", exp_q.size(), 0);

    // 6: key word offered while running is not taken
    iKey_valid = 1'b1;
    iKey_word  = 32'h0000_DEAD;
    #1;
    chk("run_krdy", 32'(oKey_ready), 32'd0);
    step();
    iKey_valid = 1'b0;
    #1;
    chk("run_kcnt", 32'(oKey_count), 32'd16);
    chk("run_can", 32'(oCan_encrypt), 32'd1);
    chk("run_seg", 32'(oSeg_index), 32'd1);

    // 5: reset after 7 key words; data and rekey ignored while loading
    do_reset();
    for (int i = 0; i < 7; i++) begin
      iKey_valid = 1'b1;
      iKey_word  = i;
      step();
    end
    iKey_valid = 1'b0;
    #1;
    chk("part_cnt", 32'(oKey_count), 32'd7);
    iData_valid = 1'b1;
    iRekey      = 1'b1;
    #1;
    chk("load_drdy", 32'(oData_ready), 32'd0);
    step();
    idle_inputs();
    #1;
    chk("load_rekey_cnt", 32'(oKey_count), 32'd7);
    chk("load_vld", 32'(oData_valid), 32'd0);
    do_reset();
    chk("rst7_cnt", 32'(oKey_count), 32'd0);
    chk("rst7_krdy", 32'(oKey_ready), 32'd1);
    chk("rst7_can", 32'(oCan_encrypt), 32'd0);

    // 5: reset mid-stream with a word held in the output register
    load_key(32'h5555_0000, 32'h1);
    iOut_ready  = 1'b0;
    iData_valid = 1'b1;
    iData       = 32'h0000_00AA;
    step();
    iData_valid = 1'b0;
    step();
    #1;
    chk("pre_rst_vld", 32'(oData_valid), 32'd1);
    do_reset();
    chk("rstm_vld", 32'(oData_valid), 32'd0);
    chk("rstm_dat", oData, 32'd0);
    chk("rstm_seg", 32'(oSeg_index), 32'd0);
    chk("rstm_can", 32'(oCan_encrypt), 32'd0);
    chk("rstm_cnt", 32'(oKey_count), 32'd0);
    iData_valid = 1'b1;
    #1;
    chk("rstm_drdy", 32'(oData_ready), 32'd0);
    iData_valid = 1'b0;
    load_key(32'h0000_0100, 32'h1);
    iOut_ready  = 1'b1;
    iData_valid = 1'b1;
    iData       = 32'h0000_0001;
    step();
    iData_valid = 1'b0;
    #1;
    chk("resume_dat", oData, 32'h0000_0101);
    step();
    step();
    chk("q_empty5", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
